// File: rtl/decode_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue: immediate-format
// encodings, the opcodes the pre-decoder recognises, and the queue entry layout.
package decode_queue_pkg;

  localparam int WIDTH   = 24;
  localparam int C_WIDTH = 2;
  localparam int I_WIDTH = 31;

  typedef enum logic [C_WIDTH:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_NONE = 3'b111
  } imm_src_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [I_WIDTH:0] pc;
    logic [WIDTH:0]   imm;
    imm_src_e         immsrc;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             illegal;
  } entry_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch/decode handshake bundle for decode_queue; master is the environment,
// slave is the queue itself.
interface decode_queue_if
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [I_WIDTH:0]         in_instr;
  logic [I_WIDTH:0]         in_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [I_WIDTH:0]         out_pc;
  logic [WIDTH:0]           out_imm;
  logic [C_WIDTH:0]         out_immSrc;
  logic [4:0]               out_rd;
  logic [4:0]               out_rs1;
  logic [4:0]               out_rs2;
  logic                     out_illegal;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_immSrc,
           out_rd, out_rs1, out_rs2, out_illegal, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_immSrc,
           out_rd, out_rs1, out_rs2, out_illegal, count
  );
endinterface

// File: rtl/decode_queue_imm_precode.sv
// Opcode to {immediate format, illegal} mapper; purely combinational so decode
// can instantiate the same table for its own cross-checks.
module imm_precode
  import decode_queue_pkg::*;
(
  input  logic [6:0] opcode,
  output imm_src_e   imm_src,
  output logic       illegal
);
  always_comb begin
    imm_src = IMM_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm_src = IMM_I;
      OP_STORE:                 imm_src = IMM_S;
      OP_BRANCH:                imm_src = IMM_B;
      OP_LUI, OP_AUIPC:         imm_src = IMM_U;
      OP_JAL:                   imm_src = IMM_J;
      OP_REG:                   imm_src = IMM_NONE;
      default:                  illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/decode_queue.sv
// Circular instruction queue between fetch and decode with enqueue-time pre-decode.
// DECODE_QUEUE_BYPASS_EN enables a zero-latency path through an empty queue.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  decode_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW:0]     cnt;
  logic            full;
  logic            empty;
  logic            byp;
  logic            enq;
  logic            deq;
  imm_src_e        in_src;
  logic            in_ill;
  entry_t          in_entry;
  entry_t          out_entry;

  imm_precode u_precode (
    .opcode  (q.in_instr[6:0]),
    .imm_src (in_src),
    .illegal (in_ill)
  );

  assign in_entry = '{pc:      q.in_pc,
                      imm:     q.in_instr[31:7],
                      immsrc:  in_src,
                      rd:      q.in_instr[11:7],
                      rs1:     q.in_instr[19:15],
                      rs2:     q.in_instr[24:20],
                      illegal: in_ill};

  assign full  = (cnt == (PW+1)'(DEPTH));
  assign empty = (cnt == '0);

`ifdef DECODE_QUEUE_BYPASS_EN
  assign byp = empty & q.in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif

  // A bypassed instruction that decode takes immediately is never stored.
  assign enq = q.in_valid & ~full & ~(byp & q.out_ready);
  assign deq = ~empty & q.out_ready;

  assign out_entry     = byp ? in_entry : mem[head];
  assign q.in_ready    = ~full;
  assign q.out_valid   = ~empty | byp;
  assign q.out_pc      = out_entry.pc;
  assign q.out_imm     = out_entry.imm;
  assign q.out_immSrc  = out_entry.immsrc;
  assign q.out_rd      = out_entry.rd;
  assign q.out_rs1     = out_entry.rs1;
  assign q.out_rs2     = out_entry.rs2;
  assign q.out_illegal = out_entry.illegal;
  assign q.count       = cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq) begin
        mem[tail] <= in_entry;
        tail      <= tail + PW'(1);
      end
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: the driver queues expected entries, a
// negedge monitor checks every entry decode accepts.
module tb_decode_queue;
  import decode_queue_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(4)) dq ();

  decode_queue #(.DEPTH(4)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .q       (dq.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  src;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Directed vectors with hand-derived immediate format and illegal flag.
  localparam int NV = 11;
  logic [31:0] v_instr [NV] = '{32'h00500093, 32'h0020A423, 32'h00208463, 32'h123450B7,
                                32'h008000EF, 32'h002081B3, 32'h0000007F, 32'h0000A103,
                                32'h000080E7, 32'h00000017, 32'h00000073};
  logic [2:0]  v_src [NV]   = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111, 3'b111,
                                3'b000, 3'b000, 3'b011, 3'b111};
  logic        v_ill [NV]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic enq(input int idx, input logic [31:0] pc, input bit accept);
    exp_t e;
    dq.in_valid = 1'b1;
    dq.in_instr = v_instr[idx];
    dq.in_pc    = pc;
    if (accept) begin
      e.pc = pc; e.instr = v_instr[idx]; e.src = v_src[idx]; e.ill = v_ill[idx];
      sb.push_back(e);
    end
    tick(1);
    dq.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && dq.out_valid && dq.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual_pc=%h required=no_entry", dq.out_pc);
      end else begin
        e = sb.pop_front();
        chk("pop_pc",      dq.out_pc,                e.pc);
        chk("pop_imm",     32'(dq.out_imm),          32'(e.instr[31:7]));
        chk("pop_immSrc",  32'(dq.out_immSrc),       32'(e.src));
        chk("pop_illegal", 32'(dq.out_illegal),      32'(e.ill));
        chk("pop_regs",    {17'd0, dq.out_rd, dq.out_rs1, dq.out_rs2},
                           {17'd0, e.instr[11:7], e.instr[19:15], e.instr[24:20]});
      end
    end
  end

  initial begin
    reset_n      = 1'b0;
    flush        = 1'b0;
    dq.in_valid  = 1'b0;
    dq.in_instr  = '0;
    dq.in_pc     = '0;
    dq.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(dq.out_valid), 32'd0);
    chk("rst_in_ready",  32'(dq.in_ready),  32'd1);
    chk("rst_count",     32'(dq.count),     32'd0);
    chk("rst_out_pc",    dq.out_pc,         32'd0);
    chk("rst_out_imm",   32'(dq.out_imm),   32'd0);
    chk("rst_immSrc",    32'(dq.out_immSrc), 32'd0);
    #20 reset_n = 1'b1;
    tick(1);

    // First enqueue: visible one edge later.
    enq(0, 32'h100, 1'b1);
    chk("addi_valid",  32'(dq.out_valid),  32'd1);
    chk("addi_imm",    32'(dq.out_imm),    32'h00A001);
    chk("addi_immSrc", 32'(dq.out_immSrc), 32'd0);
    chk("addi_rd",     32'(dq.out_rd),     32'd1);
    chk("addi_pc",     dq.out_pc,          32'h100);
    chk("addi_count",  32'(dq.count),      32'd1);
    dq.out_ready = 1'b1;
    tick(1);

    // Streaming through every opcode class.
    for (int i = 1; i < NV; i++) enq(i, 32'h104 + 32'(4 * i), 1'b1);
    tick(2);
    chk("stream_count", 32'(dq.count), 32'd0);

    // Fill to full; fifth offer refused; full-cycle dequeue does not admit new.
    dq.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) enq(i + 1, 32'h200 + 32'(4 * i), 1'b1);
    chk("full_count",    32'(dq.count),    32'd4);
    chk("full_in_ready", 32'(dq.in_ready), 32'd0);
    enq(5, 32'h210, 1'b0);
    chk("full_refuse_count", 32'(dq.count), 32'd4);
    dq.out_ready = 1'b1;
    enq(6, 32'h214, 1'b0);
    chk("full_deq_count",    32'(dq.count),    32'd3);
    chk("full_deq_in_ready", 32'(dq.in_ready), 32'd1);
    tick(3);
    chk("full_drained", 32'(dq.count), 32'd0);

    // Concurrent enqueue/dequeue across pointer wrap.
    dq.out_ready = 1'b0;
    enq(7, 32'h300, 1'b1);
    enq(8, 32'h304, 1'b1);
    dq.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      enq(i % NV, 32'h308 + 32'(4 * i), 1'b1);
      chk("wrap_count", 32'(dq.count), 32'd2);
    end
    tick(2);
    chk("wrap_drained", 32'(dq.count), 32'd0);

    // Flush beats a same-cycle enqueue.
    dq.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) enq(i, 32'h400 + 32'(4 * i), 1'b1);
    chk("pre_flush_count", 32'(dq.count), 32'd3);
    flush = 1'b1;
    enq(3, 32'h40C, 1'b0);
    flush = 1'b0;
    sb.delete();
    chk("flush_count",     32'(dq.count),     32'd0);
    chk("flush_out_valid", 32'(dq.out_valid), 32'd0);
    chk("flush_in_ready",  32'(dq.in_ready),  32'd1);
    dq.out_ready = 1'b1;
    enq(4, 32'h500, 1'b1);
    tick(1);

    // Asynchronous reset mid-stream.
    dq.out_ready = 1'b0;
    enq(1, 32'h600, 1'b1);
    enq(2, 32'h604, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_out_valid", 32'(dq.out_valid), 32'd0);
    chk("arst_in_ready",  32'(dq.in_ready),  32'd1);
    chk("arst_count",     32'(dq.count),     32'd0);
    chk("arst_out_pc",    dq.out_pc,         32'd0);
    chk("arst_out_imm",   32'(dq.out_imm),   32'd0);
    #2 reset_n = 1'b1;
    tick(1);
    dq.out_ready = 1'b1;
    enq(3, 32'h700, 1'b1);
    tick(2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
